// File: rtl/sar_pkg.sv
// Shared types and defaults for the 5-bit SAR controller.
package sar_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMP,
    S_SETL,
    S_CMPR,
    S_DONE
  } sar_state_e;

  localparam int NBIT_DEF  = 5;
  localparam int NSAMP_DEF = 2;
  localparam int TMO_DEF   = 15;

  // Width of a counter/index able to hold values 0..n-1, never below 1 bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sar_cmp_wdog.sv
// Comparator watchdog: counts consecutive armed cycles and flags expiry on the
// TMO-th one. Only instantiated when SAR_CMP_TIMEOUT_EN is defined.
module sar_cmp_wdog
  import sar_pkg::*;
#(
  parameter int TMO = TMO_DEF
) (
  input  logic CK,
  input  logic RST,
  input  logic ARM,
  input  logic CLR,
  output logic EXP
);

  localparam int CW = cnt_w(TMO + 1);
  localparam logic [CW-1:0] LAST = CW'(TMO - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count while armed, restart on any decision or state change, saturate at the last cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (CLR || !ARM)       cnt_d = '0;
    else if (cnt_q != LAST) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign EXP = ARM && (cnt_q == LAST);

endmodule

// File: rtl/sar_ctrl_5b.sv
// SAR controller for the 5-bit binary-weighted CDAC: sample, MSB..LSB trials with
// a comparator strobe handshake, then a valid/ack return of the resolved code.
// Zero-wait latency: the START-sampling edge counts as 1, DVLD rises on edge
// NSAMP + 2*NBIT + 1. Optional comparator timeout: define SAR_CMP_TIMEOUT_EN.
module sar_ctrl_5b
  import sar_pkg::*;
#(
  parameter int NBIT  = NBIT_DEF,
  parameter int NSAMP = NSAMP_DEF
`ifdef SAR_CMP_TIMEOUT_EN
  ,
  parameter int TMO   = TMO_DEF
`endif
) (
  input  logic            CK,
  input  logic            RST,
  input  logic            START,
  output logic            SAMPLE,
  output logic [NBIT-1:0] CB,
  output logic            CMP_EN,
  input  logic            CMP_RDY,
  input  logic            CMP,
  output logic [NBIT-1:0] DOUT,
  output logic            DVLD,
  input  logic            DACK,
  output logic            BUSY,
  output logic            ERR
);

  localparam int PTR_W = cnt_w(NBIT);
  localparam logic [PTR_W-1:0] PTR_MSB   = PTR_W'(NBIT - 1);
  localparam logic [3:0]       SAMP_LAST = 4'(NSAMP - 1);

  sar_state_e      state_q, state_d;
  logic [NBIT-1:0] cb_q, cb_d;
  logic [NBIT-1:0] dout_q, dout_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [3:0]      scnt_q, scnt_d;
  logic            resolve, bitv, tmo_exp;

  // Next-state: sampling window, trial sequencing, result hand-off.
  always_comb begin
    state_d = state_q;
    cb_d    = cb_q;
    dout_d  = dout_q;
    ptr_d   = ptr_q;
    scnt_d  = scnt_q;
    resolve = 1'b0;
    bitv    = 1'b0;
    if (state_q == S_CMPR) begin
      // A real decision wins over a coincident timeout; a timeout resolves as 0.
      resolve = CMP_RDY | tmo_exp;
      bitv    = CMP_RDY & CMP;
    end
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_SAMP;
          cb_d    = '0;
          ptr_d   = PTR_MSB;
          scnt_d  = '0;
        end
      end
      S_SAMP: begin
        if (scnt_q == SAMP_LAST) begin
          state_d        = S_SETL;
          cb_d[NBIT-1]   = 1'b1;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      S_SETL: state_d = S_CMPR;
      S_CMPR: begin
        if (resolve) begin
          cb_d[ptr_q] = bitv;
          if (ptr_q != '0) begin
            cb_d[ptr_q - 1'b1] = 1'b1;
            ptr_d   = ptr_q - 1'b1;
            state_d = S_SETL;
          end else begin
            dout_d  = cb_d;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (DACK) begin
          cb_d = '0;
          if (START) begin
            // Back-to-back: skip IDLE and start tracking on the next cycle.
            state_d = S_SAMP;
            ptr_d   = PTR_MSB;
            scnt_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cb_q    <= '0;
      dout_q  <= '0;
      ptr_q   <= PTR_MSB;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cb_q    <= cb_d;
      dout_q  <= dout_d;
      ptr_q   <= ptr_d;
      scnt_q  <= scnt_d;
    end
  end

`ifdef SAR_CMP_TIMEOUT_EN
  logic err_q;
  logic wd_clr;

  assign wd_clr = CMP_RDY | (state_d != state_q);

  sar_cmp_wdog #(.TMO(TMO)) u_wdog (
    .CK  (CK),
    .RST (RST),
    .ARM (state_q == S_CMPR),
    .CLR (wd_clr),
    .EXP (tmo_exp)
  );

  // Sticky timeout flag, cleared when a new conversion is accepted from IDLE.
  always_ff @(posedge CK or posedge RST) begin
    if (RST)                                      err_q <= 1'b0;
    else if (state_q == S_IDLE && START)          err_q <= 1'b0;
    else if (state_q == S_CMPR && tmo_exp && !CMP_RDY) err_q <= 1'b1;
  end

  assign ERR = err_q;
`else
  assign tmo_exp = 1'b0;
  assign ERR     = 1'b0;
`endif

  assign SAMPLE = (state_q == S_SAMP);
  assign CMP_EN = (state_q == S_CMPR);
  assign BUSY   = (state_q == S_SAMP) || (state_q == S_SETL) || (state_q == S_CMPR);
  assign DVLD   = (state_q == S_DONE);
  assign CB     = cb_q;
  assign DOUT   = dout_q;

endmodule

// File: tb/tb_sar_ctrl_5b.sv
// Bench for sar_ctrl_5b: table of conversions against a behavioural comparator,
// plus sequences for DONE hold/back-to-back, async reset, and comparator timeout.
module tb_sar_ctrl_5b;

  logic       CK = 1'b0, RST = 1'b1, START = 1'b0, CMP_RDY = 1'b0, CMP = 1'b0, DACK = 1'b0;
  logic       SAMPLE, CMP_EN, DVLD, BUSY, ERR;
  logic [4:0] CB, DOUT;

  always #5 CK = ~CK;

`ifdef SAR_CMP_TIMEOUT_EN
  sar_ctrl_5b #(.NBIT(5), .NSAMP(2), .TMO(4)) dut (
    .CK(CK), .RST(RST), .START(START), .SAMPLE(SAMPLE), .CB(CB), .CMP_EN(CMP_EN),
    .CMP_RDY(CMP_RDY), .CMP(CMP), .DOUT(DOUT), .DVLD(DVLD), .DACK(DACK), .BUSY(BUSY), .ERR(ERR));
`else
  sar_ctrl_5b #(.NBIT(5), .NSAMP(2)) dut (
    .CK(CK), .RST(RST), .START(START), .SAMPLE(SAMPLE), .CB(CB), .CMP_EN(CMP_EN),
    .CMP_RDY(CMP_RDY), .CMP(CMP), .DOUT(DOUT), .DVLD(DVLD), .DACK(DACK), .BUSY(BUSY), .ERR(ERR));
`endif

  int n_cmp = 0, n_bad = 0;

  // Comparator model: mode 0 ideal (vin >= CB), 1 always 1, 2 always 0.
  logic [4:0] vin = '0;
  int         mode = 0, rsp_delay = 0, wcnt = 0, en_cycles = 0, samp_cycles = 0;
  bit         mute_msb = 1'b0;
  logic [4:0] trials[$];

  always @(posedge CK) begin
    #1;
    if (SAMPLE) samp_cycles++;
    if (CMP_EN) begin
      en_cycles++;
      if (mute_msb && CB == 5'h10) begin
        CMP_RDY = 1'b0;
      end else if (wcnt == rsp_delay) begin
        CMP_RDY = 1'b1;
        case (mode)
          0:       CMP = (vin >= CB);
          1:       CMP = 1'b1;
          default: CMP = 1'b0;
        endcase
        trials.push_back(CB);
      end else begin
        CMP_RDY = 1'b0;
      end
      wcnt++;
    end else begin
      CMP_RDY = 1'b0;
      CMP     = 1'b0;
      wcnt    = 0;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Count edges until DVLD; lat arrives holding the count already elapsed.
  task automatic wait_dvld(inout int lat);
    while (!DVLD && lat < 200) begin
      @(posedge CK); #2;
      lat++;
    end
    if (!DVLD) chk("dvld_timeout", 0, 1);
  endtask

  // Request a conversion; latency counts the START-sampling edge as 1.
  task automatic run_conv(output int lat);
    trials.delete();
    en_cycles   = 0;
    samp_cycles = 0;
    START = 1'b1;
    @(posedge CK); #1 START = 1'b0; #1;
    lat = 1;
    wait_dvld(lat);
  endtask

  task automatic ack();
    DACK = 1'b1;
    @(posedge CK); #1 DACK = 1'b0; #1;
    chk("ack_dvld_low", int'(DVLD), 0);
    chk("ack_busy_low", int'(BUSY), 0);
  endtask

  typedef struct {
    logic [4:0] vin;
    int         mode;
    int         dly;
    logic [4:0] dout;
    int         lat;
  } vec_t;

  localparam int NV = 8;
  vec_t       vecs[NV];
  logic [4:0] exp_tr[5];

  initial begin
    int  lat;
    bit  hit;

    vecs[0] = '{5'h13, 0, 0, 5'h13, 13};
    vecs[1] = '{5'h00, 1, 0, 5'h1F, 13};
    vecs[2] = '{5'h1F, 2, 0, 5'h00, 13};
    vecs[3] = '{5'h13, 0, 3, 5'h13, 28};
    vecs[4] = '{5'h00, 0, 0, 5'h00, 13};
    vecs[5] = '{5'h1F, 0, 0, 5'h1F, 13};
    vecs[6] = '{5'h0A, 0, 1, 5'h0A, 18};
    vecs[7] = '{5'h15, 0, 2, 5'h15, 23};
    exp_tr[0] = 5'h10; exp_tr[1] = 5'h18; exp_tr[2] = 5'h14; exp_tr[3] = 5'h12; exp_tr[4] = 5'h13;

    // Reset state.
    #12;
    chk("reset_outs", int'({SAMPLE, CB, CMP_EN, DOUT, DVLD, BUSY, ERR}), 0);
    @(negedge CK) RST = 1'b0;
    @(posedge CK); #2;

    // DACK with no valid result does nothing.
    DACK = 1'b1;
    @(posedge CK); #1 DACK = 1'b0; #1;
    chk("dack_idle", int'({DVLD, BUSY, SAMPLE}), 0);

    // Table of conversions.
    for (int i = 0; i < NV; i++) begin
      vin = vecs[i].vin; mode = vecs[i].mode; rsp_delay = vecs[i].dly;
      run_conv(lat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_dout", i), int'(DOUT), int'(vecs[i].dout));
      chk($sformatf("v%0d_cb_final", i), int'(CB), int'(vecs[i].dout));
      chk($sformatf("v%0d_busy_low", i), int'(BUSY), 0);
      chk($sformatf("v%0d_cmp_en_cycles", i), en_cycles, 5 * (vecs[i].dly + 1));
      chk($sformatf("v%0d_sample_cycles", i), samp_cycles, 2);
      if (i == 0) begin
        chk("v0_trial_count", trials.size(), 5);
        for (int k = 0; k < 5 && k < trials.size(); k++)
          chk($sformatf("v0_trial%0d", k), int'(trials[k]), int'(exp_tr[k]));
      end
      ack();
    end

    // DONE hold: START ignored without DACK, then DACK+START goes straight to SAMP.
    vin = 5'h0C; mode = 0; rsp_delay = 0;
    run_conv(lat);
    START = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge CK); #2;
      chk($sformatf("hold%0d_samp_dvld_busy", k), int'({SAMPLE, DVLD, BUSY}), 3'b010);
    end
    chk("hold_dout", int'(DOUT), 5'h0C);
    DACK = 1'b1;
    @(posedge CK); #1 DACK = 1'b0; START = 1'b0; #1;
    chk("b2b_samp_dvld_busy", int'({SAMPLE, DVLD, BUSY}), 3'b101);
    lat = 1;
    wait_dvld(lat);
    chk("b2b_latency", lat, 13);
    chk("b2b_dout", int'(DOUT), 5'h0C);
    ack();

    // Reset during the bit-2 compare aborts asynchronously.
    vin = 5'h13; rsp_delay = 3;
    START = 1'b1;
    @(posedge CK); #1 START = 1'b0; #1;
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(posedge CK); #2;
      if (CMP_EN && CB == 5'h14) hit = 1'b1;
    end
    chk("reach_bit2_cmpr", int'(hit), 1);
    #3 RST = 1'b1;
    #1 chk("async_rst_outs", int'({SAMPLE, CB, CMP_EN, DOUT, DVLD, BUSY, ERR}), 0);
    @(negedge CK); @(negedge CK) RST = 1'b0;
    repeat (3) @(posedge CK);
    #2 chk("post_rst_idle", int'({DVLD, BUSY, SAMPLE}), 0);
    rsp_delay = 0;
    run_conv(lat);
    chk("post_rst_latency", lat, 13);
    chk("post_rst_dout", int'(DOUT), 5'h13);
    ack();

`ifdef SAR_CMP_TIMEOUT_EN
    // MSB never answered: resolves 0 after 4 CMPR cycles, ERR sticks until next START.
    vin = 5'h13; mode = 0; rsp_delay = 0; mute_msb = 1'b1;
    run_conv(lat);
    chk("tmo_latency", lat, 16);
    chk("tmo_dout", int'(DOUT), 5'h0F);
    chk("tmo_dout_msb", int'(DOUT[4]), 0);
    chk("tmo_err", int'(ERR), 1);
    chk("tmo_cmp_en_cycles", en_cycles, 8);
    ack();
    chk("tmo_err_sticky", int'(ERR), 1);
    mute_msb = 1'b0;
    run_conv(lat);
    chk("tmo_err_cleared", int'(ERR), 0);
    chk("tmo_next_dout", int'(DOUT), 5'h13);
    ack();
`else
    chk("err_tied_low", int'(ERR), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
